uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Serial receive front-end that feeds the UART interface framer. Recovers 8N1 bytes from the asynchronous `RxD` pin using a fixed-ratio bit clock derived from `ClkFrequency/Baud`, and presents each byte with a one-cycle strobe. Also reports line-idle state and a one-cycle end-of-packet pulse; the framer uses that pulse to resynchronise its byte counter between host frames. Framing errors are flagged and the bad byte is discarded.

## Interface
- `ClkFrequency`, 12000000, system clock in Hz.
- `Baud`, 2000000, line rate in bit/s.
- `IdleBits`, 2, bit-times of continuous high line that define idle / end of packet.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RxD`  in  1  asynchronous serial input, idle high.
- `RxD_data`  out  8  last good byte, LSB received first; holds until next good byte.
- `RxD_data_ready`  out  1  one-cycle strobe, `RxD_data` valid in the same cycle.
- `RxD_idle`  out  1  level, high while the line has been high ≥ `IdleBits` bit-times.
- `RxD_endofpacket`  out  1  one-cycle pulse when idle is reached after ≥1 good byte.
- `RxD_frame_err`  out  1  one-cycle pulse on stop bit sampled low.

## Operation
- CPB (clocks per bit) = (ClkFrequency + Baud/2) / Baud, integer. Defaults give CPB = 6. Legal range is 4..65535; counters are 16 bit. HALF = CPB/2, truncated.
- `RxD` passes through a 2-flop synchroniser to give `rxd_s`. All decisions use `rxd_s`.
- States:
  - IDLE: `rxd_s`==0 → START, with bit counter cleared.
  - START: at count HALF, `rxd_s`==0 → DATA with counter cleared. If `rxd_s`==1 it is a glitch → IDLE, and nothing is reported.
  - DATA: sample every CPB clocks, 8 samples shifted in LSB first, then → STOP.
  - STOP: sample after a further CPB clocks.
    - Sample 1: load `RxD_data`, pulse `RxD_data_ready`, set `pkt_pending`, → IDLE.
    - Sample 0: pulse `RxD_frame_err`; `RxD_data` is unchanged; → BREAK.
  - BREAK: wait for `rxd_s`==1, → IDLE.
- Idle counter:
  - Counts consecutive cycles with state==IDLE and `rxd_s`==1.
  - Saturates at IdleBits×CPB.
  - Clears on any other cycle.
- `RxD_idle` = counter at saturation.
- On the cycle the counter first reaches saturation with `pkt_pending`=1: pulse `RxD_endofpacket` and clear `pkt_pending`.
- Framing-error bytes never set `pkt_pending`.
- A falling `rxd_s` in IDLE drops `RxD_idle` the next cycle.

## Timing
- Reset values:
  - `RxD_data`=0x00, `RxD_data_ready`=0, `RxD_endofpacket`=0, `RxD_frame_err`=0, `RxD_idle`=0.
  - State IDLE, idle counter 0, `pkt_pending`=0.
  - Synchroniser flops reset to 1.
- Reset mid-byte abandons the byte: no strobe, no error.
- After reset with line high, `RxD_idle` rises after IdleBits×CPB cycles with no `RxD_endofpacket`.
- Latency: let cycle t0 be the first cycle `rxd_s`==0 in IDLE.
  - Start check at t0+HALF.
  - Data bit k is sampled at t0+HALF+(k+1)·CPB.
  - Stop is sampled at t0+HALF+9·CPB.
  - `RxD_data_ready` / `RxD_frame_err` are asserted at t0+HALF+9·CPB+1. With defaults this is t0+58.
  - From a pin edge, add 2 cycles of synchroniser delay.
- Back-to-back bytes: a start bit whose `rxd_s` falls in the first IDLE cycle after STOP is accepted. No dead time is required beyond the stop-bit sample.
- `RxD_data_ready`, `RxD_frame_err` and `RxD_endofpacket` are mutually exclusive in any cycle.
- `RxD_endofpacket` occurs no earlier than IdleBits×CPB cycles after the last strobe.

## Test plan
- **Single byte**: defaults, 0xA5 at 2 Mbaud (6 clk/bit) after reset.
  - One `RxD_data_ready` at t0+58 with `RxD_data`=0xA5.
  - `RxD_frame_err` never asserts.
- **Glitch reject**: `RxD` low for 2 clocks, otherwise high.
  - No strobe, no error, state returns to IDLE.
  - `RxD_idle` recovers after 12 high cycles.
- **Packet**: 0x77, 0x69 back-to-back, then line high.
  - Two strobes with 0x77 then 0x69.
  - Exactly one `RxD_endofpacket`, 12 cycles after the last stop sample's IDLE entry.
  - `RxD_idle` is high from that cycle.
- **Framing error**: byte 0x3C with stop bit held low for 3 bit-times, then high.
  - One `RxD_frame_err` pulse; `RxD_data` retains its previous value.
  - No strobe; no `RxD_endofpacket` afterwards if no good byte preceded it.
- **Reset mid-byte**: assert `rst` for 1 cycle during data bit 4 of 0xFF, then send 0x12.
  - No output for the aborted byte.
  - 0x12 is received correctly.
  - All outputs are zero in the cycle after reset.
- **Rate parameter**: ClkFrequency=12000000, Baud=115200 (CPB=104), byte 0x5A.
  - `RxD_data`=0x5A strobed at t0+52+936+1 = t0+989.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// 8N1 serial receive deframer: synchronises RxD, recovers bytes with a fixed
// clocks-per-bit counter, and reports idle, end-of-packet and framing errors.
module uart_rx_deframer #(
  parameter int unsigned ClkFrequency = 12000000,
  parameter int unsigned Baud         = 2000000,
  parameter int unsigned IdleBits     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  output logic       RxD_endofpacket,
  output logic       RxD_frame_err
);

  localparam int unsigned CPB      = (ClkFrequency + Baud / 2) / Baud;
  localparam int unsigned HALF     = CPB / 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDLE_MAX = IdleBits * CPB;
  localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [CNT_W-1:0]  CPB_C      = CNT_W'(CPB);
  localparam logic [CNT_W-1:0]  HALF_C     = CNT_W'(HALF);
  localparam logic [IDLE_W-1:0] IDLE_MAX_C = IDLE_W'(IDLE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bits;
  logic [7:0]        r_shift;
  logic [7:0]        r_data;
  logic              r_ready;
  logic              r_ferr;
  logic              r_eop;
  logic              r_idle;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_pkt_pending;

  logic              w_rxd_s;
  state_t            w_state;
  logic [CNT_W-1:0]  w_cnt;
  logic [2:0]        w_bits;
  logic [7:0]        w_shift;
  logic [7:0]        w_data;
  logic              w_ready;
  logic              w_ferr;
  logic              w_eop;
  logic              w_idle;
  logic [IDLE_W-1:0] w_idle_cnt;
  logic              w_pkt_pending;

  assign w_rxd_s = r_sync2;

  // State and datapath registers; synchroniser resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_bits        <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_ready       <= 1'b0;
      r_ferr        <= 1'b0;
      r_eop         <= 1'b0;
      r_idle        <= 1'b0;
      r_idle_cnt    <= '0;
      r_pkt_pending <= 1'b0;
    end else begin
      r_sync1       <= RxD;
      r_sync2       <= r_sync1;
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_bits        <= w_bits;
      r_shift       <= w_shift;
      r_data        <= w_data;
      r_ready       <= w_ready;
      r_ferr        <= w_ferr;
      r_eop         <= w_eop;
      r_idle        <= w_idle;
      r_idle_cnt    <= w_idle_cnt;
      r_pkt_pending <= w_pkt_pending;
    end
  end

  // Next-state, bit timing and output strobes.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_bits        = r_bits;
    w_shift       = r_shift;
    w_data        = r_data;
    w_ready       = 1'b0;
    w_ferr        = 1'b0;
    w_eop         = 1'b0;
    w_idle_cnt    = r_idle_cnt;
    w_pkt_pending = r_pkt_pending;

    // The bit counter is preloaded with 1 so a match on N lands N cycles later.
    case (r_state)
      S_IDLE: begin
        if (!w_rxd_s) begin
          w_state = S_START;
          w_cnt   = CNT_W'(1);
        end
      end
      S_START: begin
        if (r_cnt == HALF_C) begin
          if (!w_rxd_s) begin
            w_state = S_DATA;
            w_cnt   = CNT_W'(1);
            w_bits  = 3'd0;
          end else begin
            w_state = S_IDLE;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == CPB_C) begin
          w_shift = {w_rxd_s, r_shift[7:1]};
          w_cnt   = CNT_W'(1);
          w_bits  = r_bits + 3'd1;
          if (r_bits == 3'd7) begin
            w_state = S_STOP;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == CPB_C) begin
          if (w_rxd_s) begin
            w_data        = r_shift;
            w_ready       = 1'b1;
            w_pkt_pending = 1'b1;
            w_state       = S_IDLE;
          end else begin
            w_ferr  = 1'b1;
            w_state = S_BREAK;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (w_rxd_s) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Idle run length; end of packet fires once on reaching saturation.
    if ((r_state == S_IDLE) && w_rxd_s) begin
      if (r_idle_cnt != IDLE_MAX_C) begin
        w_idle_cnt = r_idle_cnt + IDLE_W'(1);
        if ((w_idle_cnt == IDLE_MAX_C) && r_pkt_pending) begin
          w_eop         = 1'b1;
          w_pkt_pending = 1'b0;
        end
      end
    end else begin
      w_idle_cnt = '0;
    end

    w_idle = (w_idle_cnt == IDLE_MAX_C);
  end

  assign RxD_data        = r_data;
  assign RxD_data_ready  = r_ready;
  assign RxD_idle        = r_idle;
  assign RxD_endofpacket = r_eop;
  assign RxD_frame_err   = r_ferr;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: table of single frames, hand-written corner
// sequences, a 115200-baud instance, and a random frame stream vs. a model.
module tb_uart_rx_deframer;

  localparam int CPB      = 6;
  localparam int LAT      = 60;        // pin fall to strobe: 2 sync + HALF + 9*CPB + 1
  localparam int IDLE_CYC = 2 * CPB;
  localparam int MAXC     = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;
  logic [7:0] a_data, b_data;
  logic       a_rdy, a_idle, a_eop, a_ferr;
  logic       b_rdy, b_idle, b_eop, b_ferr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_deframer #(.ClkFrequency(12000000), .Baud(2000000), .IdleBits(2)) u_dut_a (
    .clk(clk), .rst(rst), .RxD(rxd_a),
    .RxD_data(a_data), .RxD_data_ready(a_rdy), .RxD_idle(a_idle),
    .RxD_endofpacket(a_eop), .RxD_frame_err(a_ferr)
  );

  uart_rx_deframer #(.ClkFrequency(12000000), .Baud(115200), .IdleBits(2)) u_dut_b (
    .clk(clk), .rst(rst), .RxD(rxd_b),
    .RxD_data(b_data), .RxD_data_ready(b_rdy), .RxD_idle(b_idle),
    .RxD_endofpacket(b_eop), .RxD_frame_err(b_ferr)
  );

  typedef struct {
    int         n_rdy;
    int         rdy_at;
    logic [7:0] rdy_data;
    int         n_ferr;
    int         ferr_at;
    int         n_eop;
    int         eop_at;
    logic       idle_at_eop;
    logic       idle_end;
    logic [7:0] data_end;
    logic       zero_after_rst;
  } obs_t;

  typedef struct {
    logic [7:0] byte_v;
    int         stop_low;
    int         exp_rdy;
    int         exp_ferr;
    logic [7:0] exp_data_end;
    int         exp_eop;
  } vec_t;

  // Random-run stimulus and frame-level expectations
  logic       s_wave [MAXC];
  logic       s_busy [MAXC];
  logic       s_rdy  [MAXC];
  logic       s_ferr [MAXC];
  logic [7:0] s_bval [MAXC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v, input bit sel);
    if (sel) rxd_b = v;
    else     rxd_a = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst = 1'b0;
  endtask

  // Drive one 8N1 frame (stop_low>0: stop held low that many bit-times), then tail high.
  task automatic run_frame(input bit sel, input int cpb, input logic [7:0] byte_v,
                           input int stop_low, input int tail, input int rst_at,
                           output obs_t ob);
    int         stop_len;
    int         len;
    logic       v;
    logic       rdy, ferr, eop, idle;
    logic [7:0] dat;
    stop_len = (stop_low == 0) ? cpb : stop_low * cpb;
    len      = 9 * cpb + stop_len + tail;
    ob.n_rdy = 0; ob.rdy_at = -1; ob.rdy_data = 8'h00;
    ob.n_ferr = 0; ob.ferr_at = -1; ob.n_eop = 0; ob.eop_at = -1;
    ob.idle_at_eop = 1'b0; ob.idle_end = 1'b0; ob.data_end = 8'h00;
    ob.zero_after_rst = 1'b0;
    for (int o = 0; o < len; o++) begin
      if (o < cpb)                     v = 1'b0;
      else if (o < 9 * cpb)            v = byte_v[3'(o / cpb - 1)];
      else if (o < 9 * cpb + stop_len) v = (stop_low == 0);
      else                             v = 1'b1;
      if (o == rst_at) rst = 1'b1;
      tick(v, sel);
      rdy  = sel ? b_rdy  : a_rdy;
      ferr = sel ? b_ferr : a_ferr;
      eop  = sel ? b_eop  : a_eop;
      idle = sel ? b_idle : a_idle;
      dat  = sel ? b_data : a_data;
      if (o == rst_at) begin
        rst = 1'b0;
        ob.zero_after_rst = ({dat, rdy, ferr, eop, idle} == 12'h000);
      end
      if (rdy)  begin ob.n_rdy++;  ob.rdy_at = o + 1; ob.rdy_data = dat; end
      if (ferr) begin ob.n_ferr++; ob.ferr_at = o + 1; end
      if (eop)  begin ob.n_eop++;  ob.eop_at = o + 1; ob.idle_at_eop = idle; end
    end
    ob.idle_end = idle;
    ob.data_end = dat;
  endtask

  // Random frame stream; expectations derived from frame start times and the idle rule.
  task automatic random_run(input int nframes);
    int         p, t0, h, g, k, len, c, cnt;
    logic [7:0] b;
    logic       good, rs, qual, eop, pend;
    logic [7:0] dat;
    logic [11:0] act, exp;
    for (int i = 0; i < MAXC; i++) begin
      s_wave[i] = 1'b1; s_busy[i] = 1'b0; s_rdy[i] = 1'b0; s_ferr[i] = 1'b0; s_bval[i] = 8'h00;
    end
    p = int'($urandom_range(0, 20));
    for (int f = 0; f < nframes; f++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      t0   = p + 2;
      for (int o = 0; o < CPB; o++) s_wave[p + o] = 1'b0;
      for (int j = 0; j < 8; j++)
        for (int o = 0; o < CPB; o++) s_wave[p + CPB * (j + 1) + o] = b[3'(j)];
      if (good) begin
        s_rdy[t0 + 58]  = 1'b1;
        s_bval[t0 + 58] = b;
        for (int i = t0 + 1; i <= t0 + 57; i++) s_busy[i] = 1'b1;
        g = int'($urandom_range(0, 25));
        p = p + 10 * CPB + g;
      end else begin
        k = int'($urandom_range(1, 3));
        for (int o = 0; o < k * CPB; o++) s_wave[p + 9 * CPB + o] = 1'b0;
        h = t0 + 9 * CPB + k * CPB;
        s_ferr[t0 + 58] = 1'b1;
        for (int i = t0 + 1; i <= h; i++) s_busy[i] = 1'b1;
        g = int'($urandom_range(1, 25));
        p = p + 9 * CPB + k * CPB + g;
      end
    end
    len = p + 30;
    do_reset();
    check("rand_reset", {20'h0, a_data, a_rdy, a_ferr, a_eop, a_idle}, 32'h0);
    cnt = 0; pend = 1'b0; dat = 8'h00;
    for (int i = 0; i < len; i++) begin
      tick(s_wave[i], 1'b0);
      c    = i + 1;
      rs   = (c - 1 >= 2) ? s_wave[c - 3] : 1'b1;
      qual = rs && !s_busy[c - 1];
      eop  = qual && (cnt == IDLE_CYC - 1) && pend;
      cnt  = qual ? ((cnt < IDLE_CYC) ? cnt + 1 : IDLE_CYC) : 0;
      if (eop) pend = 1'b0;
      if (s_rdy[c]) begin pend = 1'b1; dat = s_bval[c]; end
      exp = {dat, s_rdy[c], s_ferr[c], eop, (cnt == IDLE_CYC)};
      act = {a_data, a_rdy, a_ferr, a_eop, a_idle};
      check($sformatf("rand_cyc%0d", c), {20'h0, act}, {20'h0, exp});
    end
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    obs_t ob, ob2;
    int   n, n_eop, fall_at, rise_at, n_bad;
    logic seen_low;

    vecs[0] = '{8'hA5, 0, 1, 0, 8'hA5, 1};
    vecs[1] = '{8'h00, 0, 1, 0, 8'h00, 1};
    vecs[2] = '{8'hFF, 0, 1, 0, 8'hFF, 1};
    vecs[3] = '{8'h3C, 3, 0, 1, 8'hFF, 0};
    vecs[4] = '{8'h81, 0, 1, 0, 8'h81, 1};
    vecs[5] = '{8'hC3, 1, 0, 1, 8'h81, 0};

    // Reset values, then idle rises IdleBits*CPB cycles later with no end of packet
    do_reset();
    check("reset_a", {20'h0, a_data, a_rdy, a_ferr, a_eop, a_idle}, 32'h0);
    check("reset_b", {20'h0, b_data, b_rdy, b_ferr, b_eop, b_idle}, 32'h0);
    n = 0; n_eop = 0;
    while (!a_idle && n < 100) begin
      tick(1'b1, 1'b0);
      n++;
      if (a_eop) n_eop++;
    end
    check("idle_after_reset_cycles", n, IDLE_CYC);
    check("idle_after_reset_eop", n_eop, 0);

    for (int i = 0; i < 6; i++) begin
      run_frame(1'b0, CPB, vecs[i].byte_v, vecs[i].stop_low, 30, -1, ob);
      check($sformatf("vec%0d_n_rdy", i), ob.n_rdy, vecs[i].exp_rdy);
      check($sformatf("vec%0d_n_ferr", i), ob.n_ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d_n_eop", i), ob.n_eop, vecs[i].exp_eop);
      check($sformatf("vec%0d_data_end", i), ob.data_end, vecs[i].exp_data_end);
      check($sformatf("vec%0d_idle_end", i), ob.idle_end, 1);
      if (vecs[i].exp_rdy != 0) begin
        check($sformatf("vec%0d_rdy_at", i), ob.rdy_at, LAT);
        check($sformatf("vec%0d_rdy_data", i), ob.rdy_data, vecs[i].byte_v);
      end
      if (vecs[i].exp_ferr != 0) check($sformatf("vec%0d_ferr_at", i), ob.ferr_at, LAT);
      if (vecs[i].exp_eop != 0) begin
        check($sformatf("vec%0d_eop_at", i), ob.eop_at, LAT + IDLE_CYC);
        check($sformatf("vec%0d_idle_at_eop", i), ob.idle_at_eop, 1);
      end
    end

    // Glitch: two low pin cycles; idle drops, start check rejects, idle recovers
    n_bad = 0; fall_at = -1; rise_at = -1; seen_low = 1'b0;
    for (int o = 0; o < 40; o++) begin
      tick((o < 2) ? 1'b0 : 1'b1, 1'b0);
      if (a_rdy || a_ferr || a_eop) n_bad++;
      if (!a_idle && !seen_low) begin seen_low = 1'b1; fall_at = o + 1; end
      if (a_idle && seen_low && rise_at < 0) rise_at = o + 1;
    end
    check("glitch_no_output", n_bad, 0);
    check("glitch_idle_fall", fall_at, 3);
    check("glitch_idle_rise", rise_at, 5 + 1 + IDLE_CYC);

    // Packet of two back-to-back bytes
    run_frame(1'b0, CPB, 8'h77, 0, 0, -1, ob);
    run_frame(1'b0, CPB, 8'h69, 0, 30, -1, ob2);
    check("pkt_b0_data", ob.rdy_data, 8'h77);
    check("pkt_b0_n_rdy", ob.n_rdy, 1);
    check("pkt_b0_no_eop", ob.n_eop, 0);
    check("pkt_b1_rdy_at", ob2.rdy_at, LAT);
    check("pkt_b1_data", ob2.rdy_data, 8'h69);
    check("pkt_n_eop", ob2.n_eop, 1);
    check("pkt_eop_at", ob2.eop_at, LAT + IDLE_CYC);
    check("pkt_idle_at_eop", ob2.idle_at_eop, 1);

    // Reset during data bit 4 of 0xFF, then 0x12
    run_frame(1'b0, CPB, 8'hFF, 0, 20, 32, ob);
    check("rstmid_zero_after", ob.zero_after_rst, 1);
    check("rstmid_no_rdy", ob.n_rdy, 0);
    check("rstmid_no_ferr", ob.n_ferr, 0);
    check("rstmid_no_eop", ob.n_eop, 0);
    run_frame(1'b0, CPB, 8'h12, 0, 20, -1, ob);
    check("rstmid_next_rdy_at", ob.rdy_at, LAT);
    check("rstmid_next_data", ob.rdy_data, 8'h12);

    // 115200 baud instance: CPB=104, strobe 2+52+936+1 cycles after pin fall
    run_frame(1'b1, 104, 8'h5A, 0, 20, -1, ob);
    check("rate_n_rdy", ob.n_rdy, 1);
    check("rate_rdy_at", ob.rdy_at, 2 + 989);
    check("rate_data", ob.rdy_data, 8'h5A);
    check("rate_no_ferr", ob.n_ferr, 0);

    random_run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
